// File: rtl/spi_master_multi.sv
// SPI master with per-transfer CPOL/CPHA, configurable word width, divider and chip selects.
// All outputs are registered; MISO is sampled on the same clk edge that launches the SCK edge.
module spi_master_multi #(
   parameter int unsigned clk_div = 4,
   parameter int unsigned data_w  = 8,
   parameter int unsigned num_cs  = 2,
   parameter int unsigned cs_w    = (num_cs > 1) ? $clog2(num_cs) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [cs_w-1:0]   cs_sel,
   input  logic [data_w-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [data_w-1:0] rx_data,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [num_cs-1:0] spi_cs_n
);

   localparam int unsigned DivW  = (clk_div > 1) ? $clog2(clk_div) : 1;
   localparam int unsigned EdgeW = $clog2(2 * data_w + 1);

   typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_t;

   state_t             state_q, state_d;
   logic [DivW-1:0]    div_cnt_q, div_cnt_d;
   logic [EdgeW-1:0]   edge_cnt_q, edge_cnt_d;
   logic [data_w-1:0]  tx_sh_q, tx_sh_d;
   logic [data_w-1:0]  rx_sh_q, rx_sh_d;
   logic               cpha_q, cpha_d;
   logic               busy_d, done_d, sclk_d, mosi_d;
   logic [data_w-1:0]  rx_data_d;
   logic [num_cs-1:0]  cs_n_d;

   logic tick, last_half, edge_now, leading, sample, shift;

   assign tick      = (div_cnt_q == DivW'(clk_div - 1));
   assign last_half = (edge_cnt_q == EdgeW'(2 * data_w));
   // edge_cnt_q counts edges already issued, so the pending edge is odd (leading) when it is even
   assign edge_now  = tick && ((state_q == StSetup) || ((state_q == StShift) && !last_half));
   assign leading   = ~edge_cnt_q[0];
   assign sample    = edge_now && (leading != cpha_q);
   assign shift     = edge_now && !sample && (edge_cnt_q != EdgeW'(2 * data_w - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StSetup;
         StSetup: if (tick) state_d = StShift;
         StShift: if (tick && last_half) state_d = StHold;
         StHold:  if (tick) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      div_cnt_d  = div_cnt_q;
      edge_cnt_d = edge_cnt_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      cpha_d     = cpha_q;
      busy_d     = busy;
      done_d     = 1'b0;
      rx_data_d  = rx_data;
      sclk_d     = spi_clk;
      mosi_d     = spi_mosi;
      cs_n_d     = spi_cs_n;
      if (state_q == StIdle) begin
         div_cnt_d  = '0;
         edge_cnt_d = '0;
         if (start) begin
            cpha_d  = cpha;
            sclk_d  = cpol;
            busy_d  = 1'b1;
            rx_sh_d = '0;
            // CPHA=0 presents the MSB now, so the shifter starts one bit ahead
            tx_sh_d = cpha ? tx_data : (tx_data << 1);
            mosi_d  = cpha ? 1'b0 : tx_data[data_w-1];
            for (int unsigned i = 0; i < num_cs; i++) begin
               cs_n_d[i] = (cs_sel != cs_w'(i));
            end
         end
      end else begin
         div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
         if (edge_now) begin
            edge_cnt_d = edge_cnt_q + EdgeW'(1);
            sclk_d     = ~spi_clk;
         end
         if (sample) rx_sh_d = {rx_sh_q[data_w-2:0], spi_miso};
         if (shift) begin
            mosi_d  = tx_sh_q[data_w-1];
            tx_sh_d = tx_sh_q << 1;
         end
         if ((state_q == StHold) && tick) begin
            busy_d    = 1'b0;
            done_d    = 1'b1;
            cs_n_d    = '1;
            rx_data_d = rx_sh_q;
            mosi_d    = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         cpha_q     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         rx_data    <= '0;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
         spi_cs_n   <= '1;
      end else begin
         div_cnt_q  <= div_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         cpha_q     <= cpha_d;
         busy       <= busy_d;
         done       <= done_d;
         rx_data    <= rx_data_d;
         spi_clk    <= sclk_d;
         spi_mosi   <= mosi_d;
         spi_cs_n   <= cs_n_d;
      end
   end

endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master for the quadcopter system bus: it serialises one `data_w`-bit word per request onto `spi_mosi` and captures `spi_miso`. It drives one of `num_cs` active-low chip selects, and the SPI mode (CPOL/CPHA) is selectable per transfer. It sits between the CPU peripheral registers and the off-board sensors (IMU, barometer) that share one SPI bus. Compared with the fixed single-slave SPI port, it adds runtime modes, configurable word width, multiple slaves and a configurable clock divider.

## Interface
- `clk_div`, default 4: SCK half-period in `clk` cycles; must be at least 1.
- `data_w`, default 8: bits per transfer; must be at least 2.
- `num_cs`, default 2: number of chip selects; must be at least 1.
- `cs_w`, default `$clog2(num_cs)` (minimum 1): width of `cs_sel`.

- `clk`  in  1  system clock; the block uses this single clock only.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transfer; sampled in IDLE only.
- `cpol`  in  1  SCK idle level; latched at start.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
- `cs_sel`  in  cs_w  slave index; latched at start.
- `tx_data`  in  data_w  word to send, MSB first; latched at start.
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `rx_data`  out  data_w  last received word; holds until the next `done`.
- `spi_clk`  out  1  SCK.
- `spi_mosi`  out  1  master out.
- `spi_miso`  in  1  master in; treated as synchronous to `clk`, no synchroniser.
- `spi_cs_n`  out  num_cs  active-low chip selects.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- **IDLE → SETUP** when `start` is 1.
  - Latch `cpol`, `cpha`, `cs_sel` and `tx_data`.
  - Next cycle: `busy` = 1, `spi_cs_n[cs_sel]` = 0, `spi_clk` = latched `cpol`.
  - If `cpha` = 0, `spi_mosi` = `tx_data[data_w-1]`.
- **SETUP:** lasts `clk_div` cycles, then → SHIFT.
- **SHIFT:** produces 2·`data_w` SCK edges, one every `clk_div` cycles; the first edge comes at the end of SETUP.
  - Odd-numbered edges are leading edges; even-numbered edges are trailing edges.
  - `cpha` = 0: sample `spi_miso` on leading edges; shift the next MOSI bit on trailing edges, except the last one.
  - `cpha` = 1: shift the MOSI bit on leading edges (the first leading edge drives the MSB); sample on trailing edges.
  - Sampled bits shift into the receive register LSB-first, so the first bit received ends up as the MSB.
  - After the final edge, `spi_clk` = `cpol` → HOLD.
- **HOLD:** lasts `clk_div` cycles with CS still asserted, then → IDLE.
- **Entering IDLE:** in the first IDLE cycle, `done` = 1, `busy` = 0, all `spi_cs_n` = 1, `rx_data` = received word, `spi_mosi` = 0.
- **Start while busy:** `start` outside IDLE is ignored and is not queued.
- **Back-to-back:** `start` is accepted in the `done` cycle, so CS is deasserted for exactly 1 cycle between transfers.
- **Out-of-range `cs_sel`** (`cs_sel` ≥ `num_cs`): the transfer runs normally, but no `spi_cs_n` bit is asserted.
- **Mode inputs:** changes to `cpol`/`cpha` while busy have no effect; in IDLE, `spi_clk` follows the last latched `cpol`.
- **Reset mid-transfer:** all outputs return to their reset values on the next cycle; no `done` pulse; `rx_data` = 0.

## Timing
- Reset values: `busy` = 0, `done` = 0, `rx_data` = 0, `spi_clk` = 0 (latched `cpol` = 0), `spi_mosi` = 0, `spi_cs_n` = all ones.
- `busy` is high for exactly `clk_div`·(2·`data_w` + 2) cycles. With defaults: 4·18 = 72 cycles.
- `done` asserts 72 + 1 cycles after the `start` cycle (defaults).
- All outputs are registered; there is no combinational path from input to output.
- SCK high and low times are each exactly `clk_div` cycles.
- MOSI changes only on shift edges; MISO is sampled in the same `clk` cycle as the sampling SCK edge.

## Test plan
- **Mode 0, loopback:** `clk_div` = 4, `data_w` = 8, `spi_miso` tied to `spi_mosi`, `tx_data` = 0xA5, `cs_sel` = 0 → `busy` high for 72 cycles, 8 rising SCK edges, `spi_cs_n` = 2'b10 throughout, `done` pulse of 1 cycle, `rx_data` = 0xA5.
- **Mode 3, slave model:** slave model returns 0x3C, `tx_data` = 0x81, `cs_sel` = 1 → SCK idles high, slave captures 0x81, `rx_data` = 0x3C, only `spi_cs_n[1]` goes low.
- **Start while busy:** pulse `start` at cycle 20 of a transfer with `tx_data` = 0xFF → exactly one `done`, the transmitted word is unchanged, no second transfer.
- **Back-to-back:** hold `start` high across two transfers (0x12, then 0x34) → CS high for exactly 1 cycle between them, two `done` pulses 73 cycles apart, `rx_data` = 0x12 then 0x34 (loopback).
- **Reset mid-transfer:** assert `rst` at cycle 30 of a transfer → next cycle `busy` = 0, `spi_cs_n` = all ones, `spi_clk` = 0, `rx_data` = 0, no `done`; a new start then completes normally.
- **Out-of-range chip select:** `num_cs` = 3, `cs_sel` = 3 → 72-cycle transfer, `spi_cs_n` stays 3'b111, `done` still pulses.
